// File: rtl/inp_cond_pkg.sv
// Shared constants for the inp_cond input conditioner: FSM state codes and counter widths.
package inp_cond_pkg;

    localparam int unsigned FCNT_W = 4;
    localparam int unsigned QCNT_W = 3;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StPulse = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    function automatic logic [1:0] count_events(input logic [1:0] rise);
        return {1'b0, rise[0]} + {1'b0, rise[1]};
    endfunction

endpackage

// File: rtl/inp_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw button bit.
module inp_debounce #(
    parameter int unsigned DEB_CYCLES = 480000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic deb_o
);

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]      sync_q;
    logic            deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync_q[1] == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
            deb_d = ~deb_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/inp_cond.sv
// Coin/start input conditioner: debounced starts, queued frame-aligned coin pulses.
// Define INP_COIN_QUEUE_EN for a QDEPTH-deep coin queue; otherwise the queue holds one coin.
module inp_cond
    import inp_cond_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 480000,
    parameter int unsigned PULSE_FRAMES = 4,
    parameter int unsigned GAP_FRAMES   = 4,
    parameter int unsigned QDEPTH       = 7
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic              VBLK,
    input  logic [1:0]        RAW_COIN,
    input  logic [1:0]        RAW_START,
    output logic [2:0]        INP2,
    output logic [QCNT_W-1:0] COIN_PEND,
    output logic              COIN_OVF
);

`ifdef INP_COIN_QUEUE_EN
    localparam int unsigned QCap = QDEPTH;
`else
    localparam int unsigned QCap = (QDEPTH > 0) ? 1 : 0;
`endif

    logic [1:0]        coin_deb, start_deb;
    logic [1:0]        coin_prev_q;
    logic              vblk_q;
    logic [1:0]        state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [QCNT_W-1:0] pend_q, pend_d, base;
    logic              ovf_q, ovf_d;
    logic [2:0]        inp2_q, inp2_d;
    logic              tick, launch;
    logic [1:0]        rise, n_ev;
    logic [QCNT_W:0]   room, accept;

    inp_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_coin0 (
        .clk_i(MCLK), .rst_i(RESET), .raw_i(RAW_COIN[0]), .deb_o(coin_deb[0])
    );
    inp_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_coin1 (
        .clk_i(MCLK), .rst_i(RESET), .raw_i(RAW_COIN[1]), .deb_o(coin_deb[1])
    );
    inp_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start0 (
        .clk_i(MCLK), .rst_i(RESET), .raw_i(RAW_START[0]), .deb_o(start_deb[0])
    );
    inp_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start1 (
        .clk_i(MCLK), .rst_i(RESET), .raw_i(RAW_START[1]), .deb_o(start_deb[1])
    );

    assign tick = VBLK & ~vblk_q;
    assign rise = coin_deb & ~coin_prev_q;
    assign n_ev = count_events(rise);

    // The tick that ends GAP also serves as the idle tick, so back-to-back
    // pulse starts sit exactly PULSE_FRAMES+GAP_FRAMES frames apart.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        launch  = 1'b0;
        case (state_q)
            StIdle: begin
                if (tick && pend_q != '0) begin
                    launch  = 1'b1;
                    state_d = StPulse;
                    fcnt_d  = FCNT_W'(PULSE_FRAMES);
                end
            end
            StPulse: begin
                if (tick) begin
                    if (fcnt_q <= FCNT_W'(1)) begin
                        state_d = StGap;
                        fcnt_d  = FCNT_W'(GAP_FRAMES);
                    end else begin
                        fcnt_d = fcnt_q - FCNT_W'(1);
                    end
                end
            end
            StGap: begin
                if (tick) begin
                    if (fcnt_q > FCNT_W'(1)) begin
                        fcnt_d = fcnt_q - FCNT_W'(1);
                    end else if (pend_q != '0) begin
                        launch  = 1'b1;
                        state_d = StPulse;
                        fcnt_d  = FCNT_W'(PULSE_FRAMES);
                    end else begin
                        state_d = StIdle;
                        fcnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                fcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        base = pend_q - QCNT_W'(launch);
`ifdef INP_COIN_QUEUE_EN
        room = (QCNT_W+1)'(QCap) - {1'b0, base};
`else
        room = (pend_q == '0 && state_q == StIdle) ? (QCNT_W+1)'(QCap) : '0;
`endif
        accept = {{(QCNT_W-1){1'b0}}, n_ev};
        ovf_d  = ovf_q;
        if (accept > room) begin
            accept = room;
            ovf_d  = 1'b1;
        end
        pend_d = base + accept[QCNT_W-1:0];
        inp2_d = {state_d == StPulse, start_deb};
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            fcnt_q      <= '0;
            pend_q      <= '0;
            ovf_q       <= 1'b0;
            vblk_q      <= 1'b0;
            coin_prev_q <= '0;
            inp2_q      <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            vblk_q      <= VBLK;
            coin_prev_q <= coin_deb;
            inp2_q      <= inp2_d;
        end
    end

    assign INP2      = inp2_q;
    assign COIN_PEND = pend_q;
    assign COIN_OVF  = ovf_q;

endmodule
